// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared square codes, board geometry and start layout for controller and renderer
package chess_pkg;

  localparam int CHESS_SQUARES = 64;
  localparam int SQUARE_WIDTH  = 4;
  localparam int COLOUR_BIT    = 3;
  localparam int BOARD_BITS    = CHESS_SQUARES * SQUARE_WIDTH;

  typedef logic [SQUARE_WIDTH-1:0]          squareCode_t;
  typedef logic [$clog2(CHESS_SQUARES)-1:0] squareIdx_t;
  typedef logic [CHESS_SQUARES-1:0][SQUARE_WIDTH-1:0] board_t;

  localparam logic COLOUR_DARK  = 1'b0;
  localparam logic COLOUR_LIGHT = 1'b1;

  localparam squareCode_t SQ_EMPTY     = 4'h0;
  localparam squareCode_t DARK_PAWN    = 4'h1;
  localparam squareCode_t DARK_ROOK    = 4'h2;
  localparam squareCode_t DARK_KNIGHT  = 4'h3;
  localparam squareCode_t DARK_BISHOP  = 4'h4;
  localparam squareCode_t DARK_QUEEN   = 4'h5;
  localparam squareCode_t DARK_KING    = 4'h6;
  localparam squareCode_t LIGHT_PAWN   = 4'h9;
  localparam squareCode_t LIGHT_ROOK   = 4'hA;
  localparam squareCode_t LIGHT_KNIGHT = 4'hB;
  localparam squareCode_t LIGHT_BISHOP = 4'hC;
  localparam squareCode_t LIGHT_QUEEN  = 4'hD;
  localparam squareCode_t LIGHT_KING   = 4'hE;

  // Square 0 sits in the least significant nibble, so each row reads right-to-left here.
  localparam board_t INIT_LAYOUT = 256'hABCEDCBA_99999999_00000000_00000000_00000000_00000000_11111111_23465432;

  localparam squareIdx_t RESET_CURSOR = 6'd52;

  typedef enum logic {
    MOVE_IDLE     = 1'b0,
    MOVE_SELECTED = 1'b1
  } moveState_t;

  function automatic logic isColour(input squareCode_t code, input logic colour);
    return (code != SQ_EMPTY) && (code[COLOUR_BIT] == colour);
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchronizer plus stability counter for one switch or key
module input_debouncer #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rawIn,
  output logic level,
  output logic changed
);

  localparam int COUNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic               sync1;
  logic               sync2;
  logic [COUNT_W-1:0] stableCount;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
    end else begin
      sync1 <= rawIn;
      sync2 <= sync1;
    end
  end

  // Counts consecutive samples that disagree with the accepted level; any agreeing sample restarts it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level       <= RESET_LEVEL;
      stableCount <= '0;
      changed     <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (sync2 == level) begin
        stableCount <= '0;
      end else if (stableCount == COUNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level       <= sync2;
        stableCount <= '0;
        changed     <= 1'b1;
      end else begin
        stableCount <= stableCount + COUNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/chess_board_controller.sv
// rtl/chess_board_controller.sv - live board register, cursor and select/place move FSM
module chess_board_controller
  import chess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  play_enable,
  input  logic                  new_game,
  input  logic                  KeyLeft,
  input  logic                  KeyUp,
  input  logic                  KeyDown,
  input  logic                  KeyRight,
  input  logic                  LockSwitch,
  output logic [BOARD_BITS-1:0] Matrix,
  output logic [5:0]            cursor_idx,
  output logic                  select_valid,
  output logic [5:0]            select_idx,
  output logic                  turn,
  output logic                  move_done
);

  localparam int KEY_RIGHT = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_UP    = 3;

  logic [3:0] keyRaw;
  logic [3:0] keyLevel;
  logic [3:0] keyChanged;
  logic [3:0] keyPress;
  logic       lockLevel;
  logic       lockChanged;
  logic       eventsLive;
  logic       lockRise;
  logic       lockFall;

  board_t      board;
  squareIdx_t  cursor;
  squareIdx_t  nextCursor;
  squareIdx_t  selectIdx;
  logic        sideToMove;
  logic        moveDone;
  moveState_t  state;
  moveState_t  nextState;

  squareCode_t targetCode;
  squareCode_t sourceCode;
  logic        pickable;
  logic        capturable;
  logic        sameSquare;
  logic        doSelect;
  logic        doCommit;
  logic        doCancel;
  logic [2:0]  curRow;
  logic [2:0]  curCol;

  assign keyRaw = {KeyUp, KeyDown, KeyLeft, KeyRight};

  for (genvar k = 0; k < 4; k++) begin : gKeyDebounce
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (1'b1)
    ) uKeyDebounce (
      .clock  (clock),
      .reset_n(reset_n),
      .rawIn  (keyRaw[k]),
      .level  (keyLevel[k]),
      .changed(keyChanged[k])
    );
  end

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b0)
  ) uLockDebounce (
    .clock  (clock),
    .reset_n(reset_n),
    .rawIn  (LockSwitch),
    .level  (lockLevel),
    .changed(lockChanged)
  );

  // new_game swallows every other event in its cycle, and nothing acts outside play.
  assign eventsLive = play_enable && !new_game;
  assign keyPress   = keyChanged & ~keyLevel & {4{eventsLive}};
  assign lockRise   = lockChanged && lockLevel && eventsLive;
  assign lockFall   = lockChanged && !lockLevel && eventsLive;

  assign curRow = cursor[5:3];
  assign curCol = cursor[2:0];

  always_comb begin
    nextCursor = cursor;
    if (keyPress[KEY_UP]) begin
      if (curRow != 3'd0) nextCursor = {curRow - 3'd1, curCol};
    end else if (keyPress[KEY_DOWN]) begin
      if (curRow != 3'd7) nextCursor = {curRow + 3'd1, curCol};
    end else if (keyPress[KEY_LEFT]) begin
      if (curCol != 3'd0) nextCursor = {curRow, curCol - 3'd1};
    end else if (keyPress[KEY_RIGHT]) begin
      if (curCol != 3'd7) nextCursor = {curRow, curCol + 3'd1};
    end
  end

  // Lock decisions always look at the cursor before this cycle's move.
  assign targetCode = board[cursor];
  assign sourceCode = board[selectIdx];
  assign pickable   = isColour(targetCode, sideToMove);
  assign capturable = !isColour(targetCode, sideToMove);
  assign sameSquare = (cursor == selectIdx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= MOVE_IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (new_game || !play_enable) begin
      nextState = MOVE_IDLE;
    end else begin
      case (state)
        MOVE_IDLE:     if (lockRise && pickable) nextState = MOVE_SELECTED;
        MOVE_SELECTED: if (lockFall && (sameSquare || capturable)) nextState = MOVE_IDLE;
        default:       nextState = MOVE_IDLE;
      endcase
    end
  end

  always_comb begin
    doSelect = 1'b0;
    doCommit = 1'b0;
    doCancel = 1'b0;
    case (state)
      MOVE_IDLE: doSelect = lockRise && pickable;
      MOVE_SELECTED: begin
        if (lockFall) begin
          doCancel = sameSquare;
          doCommit = !sameSquare && capturable;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      board      <= INIT_LAYOUT;
      cursor     <= RESET_CURSOR;
      selectIdx  <= '0;
      sideToMove <= COLOUR_LIGHT;
      moveDone   <= 1'b0;
    end else begin
      moveDone <= 1'b0;
      if (new_game) begin
        board      <= INIT_LAYOUT;
        cursor     <= RESET_CURSOR;
        selectIdx  <= '0;
        sideToMove <= COLOUR_LIGHT;
      end else begin
        cursor <= nextCursor;
        if (doSelect) selectIdx <= cursor;
        else if (doCommit || doCancel || !play_enable) selectIdx <= '0;
        if (doCommit) begin
          board[cursor]    <= sourceCode;
          board[selectIdx] <= SQ_EMPTY;
          sideToMove       <= ~sideToMove;
          moveDone         <= 1'b1;
        end
      end
    end
  end

  assign Matrix       = board;
  assign cursor_idx   = cursor;
  assign select_valid = (state == MOVE_SELECTED);
  assign select_idx   = selectIdx;
  assign turn         = sideToMove;
  assign move_done    = moveDone;

endmodule

// File: tb/tb_chess_board_controller.sv
// tb/tb_chess_board_controller.sv - directed self-checking bench for chess_board_controller
module tb_chess_board_controller;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic play_enable = 1'b1;
  logic new_game = 1'b0;
  logic KeyLeft = 1'b1;
  logic KeyUp = 1'b1;
  logic KeyDown = 1'b1;
  logic KeyRight = 1'b1;
  logic LockSwitch = 1'b0;

  logic [255:0] matrix;
  logic [5:0]   cursorIdx;
  logic         selectValid;
  logic [5:0]   selectIdx;
  logic         turn;
  logic         moveDone;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pulseBase;

  localparam logic [255:0] START_BOARD =
    256'hABCEDCBA_99999999_00000000_00000000_00000000_00000000_11111111_23465432;
  logic [255:0] expBoard;

  chess_board_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .play_enable (play_enable),
    .new_game    (new_game),
    .KeyLeft     (KeyLeft),
    .KeyUp       (KeyUp),
    .KeyDown     (KeyDown),
    .KeyRight    (KeyRight),
    .LockSwitch  (LockSwitch),
    .Matrix      (matrix),
    .cursor_idx  (cursorIdx),
    .select_valid(selectValid),
    .select_idx  (selectIdx),
    .turn        (turn),
    .move_done   (moveDone)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (moveDone === 1'b1) pulses++;

  task automatic checkValue(input string tag, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // mask bits: {up, down, left, right}
  task automatic pressKeys(input logic [3:0] mask, input int hold);
    KeyUp    = ~mask[3];
    KeyDown  = ~mask[2];
    KeyLeft  = ~mask[1];
    KeyRight = ~mask[0];
    waitCycles(hold);
    KeyUp    = 1'b1;
    KeyDown  = 1'b1;
    KeyLeft  = 1'b1;
    KeyRight = 1'b1;
    waitCycles(10);
  endtask

  task automatic repeatKey(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) pressKeys(mask, 8);
  endtask

  task automatic setLock(input logic v);
    LockSwitch = v;
    waitCycles(10);
  endtask

  task automatic pulseNewGame();
    new_game = 1'b1;
    waitCycles(1);
    new_game = 1'b0;
    waitCycles(2);
  endtask

  initial begin
    waitCycles(3);
    checkValue("rstSq0", matrix[3:0], 4'h2);
    checkValue("rstSq8", matrix[35:32], 4'h1);
    checkValue("rstSq48", matrix[195:192], 4'h9);
    checkValue("rstSq63", matrix[255:252], 4'hA);
    checkValue("rstBoard", matrix, START_BOARD);
    checkValue("rstCursor", cursorIdx, 6'd52);
    checkValue("rstTurn", turn, 1'b1);
    checkValue("rstSelValid", selectValid, 1'b0);
    checkValue("rstSelIdx", selectIdx, 6'd0);
    checkValue("rstMoveDone", moveDone, 1'b0);
    reset_n = 1'b1;
    waitCycles(3);

    // Up press: accepted 2+4 edges after the change, cursor one edge later
    KeyUp = 1'b0;
    waitCycles(6);
    checkValue("upEarly", cursorIdx, 6'd52);
    waitCycles(1);
    checkValue("upPress", cursorIdx, 6'd44);
    waitCycles(2);
    KeyUp = 1'b1;
    waitCycles(10);
    checkValue("upHeldOnce", cursorIdx, 6'd44);
    pressKeys(4'b0010, 2);
    checkValue("leftGlitch", cursorIdx, 6'd44);
    pressKeys(4'b0100, 8);
    checkValue("downPress", cursorIdx, 6'd52);

    // Light pawn 52 -> 36
    pulseBase = pulses;
    setLock(1'b1);
    checkValue("pickValid", selectValid, 1'b1);
    checkValue("pickIdx", selectIdx, 6'd52);
    repeatKey(4'b1000, 2);
    checkValue("carryCursor", cursorIdx, 6'd36);
    setLock(1'b0);
    expBoard = START_BOARD;
    expBoard[36*4 +: 4] = 4'h9;
    expBoard[52*4 +: 4] = 4'h0;
    checkValue("moveBoard", matrix, expBoard);
    checkValue("moveTurn", turn, 1'b0);
    checkValue("moveSelValid", selectValid, 1'b0);
    checkValue("movePulses", pulses - pulseBase, 1);

    pulseBase = pulses;
    pulseNewGame();
    checkValue("ngBoard", matrix, START_BOARD);
    checkValue("ngCursor", cursorIdx, 6'd52);
    checkValue("ngTurn", turn, 1'b1);
    checkValue("ngPulses", pulses - pulseBase, 0);

    // Walk to square 0, check edge saturation
    repeatKey(4'b1000, 7);
    checkValue("topEdge", cursorIdx, 6'd4);
    repeatKey(4'b0010, 5);
    checkValue("leftEdge", cursorIdx, 6'd0);
    setLock(1'b1);
    checkValue("pickDarkOnLight", selectValid, 1'b0);
    setLock(1'b0);
    checkValue("idleFall", selectValid, 1'b0);
    checkValue("idleFallBoard", matrix, START_BOARD);

    // Own-colour target is rejected
    pulseNewGame();
    pulseBase = pulses;
    pressKeys(4'b0010, 8);
    checkValue("to51", cursorIdx, 6'd51);
    setLock(1'b1);
    checkValue("pick51", selectIdx, 6'd51);
    pressKeys(4'b0001, 8);
    setLock(1'b0);
    checkValue("rejValid", selectValid, 1'b1);
    checkValue("rejIdx", selectIdx, 6'd51);
    checkValue("rejBoard", matrix, START_BOARD);
    checkValue("rejTurn", turn, 1'b1);
    checkValue("rejPulses", pulses - pulseBase, 0);
    pressKeys(4'b1010, 8);
    checkValue("upBeatsLeft", cursorIdx, 6'd44);

    // Leaving play drops the selection and ignores keys
    play_enable = 1'b0;
    waitCycles(2);
    checkValue("pauseValid", selectValid, 1'b0);
    checkValue("pauseIdx", selectIdx, 6'd0);
    pressKeys(4'b1000, 8);
    checkValue("pauseCursor", cursorIdx, 6'd44);
    play_enable = 1'b1;
    waitCycles(2);

    // Async reset in the middle of a move
    pressKeys(4'b0100, 8);
    setLock(1'b1);
    checkValue("midPick", selectValid, 1'b1);
    pressKeys(4'b1000, 8);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    LockSwitch = 1'b0;
    #1;
    checkValue("asyncBoard", matrix, START_BOARD);
    checkValue("asyncCursor", cursorIdx, 6'd52);
    checkValue("asyncValid", selectValid, 1'b0);
    checkValue("asyncTurn", turn, 1'b1);
    @(negedge clock);
    reset_n = 1'b1;
    waitCycles(10);
    checkValue("postRstValid", selectValid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
